vid_raster_to_stream: RTL and testbench

//  Downstream of the test pattern generator. Converts raster video (hs/vs/vld/rgb) into a

---
 rtl/vid_pkg.sv | 19 +
 rtl/vid_sync_fifo.sv | 52 +++++
 rtl/vid_raster_to_stream.sv | 138 +++++++++++++
 tb/tb_vid_raster_to_stream.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/vid_pkg.sv
// rtl/vid_pkg.sv - shared types and word layout for the raster-to-stream converter
package vid_pkg;

  typedef enum logic [1:0] {
    S_SYNC   = 2'd0,
    S_ARMED  = 2'd1,
    S_ACTIVE = 2'd2
  } state_t;

  // FIFO word is {sof, eol, rgb}; tag bit positions are relative to the top of rgb
  localparam int TAG_W   = 2;
  localparam int SOF_BIT = 1;
  localparam int EOL_BIT = 0;

  function automatic int word_width(input int pw);
    return 3 * pw + TAG_W;
  endfunction

endpackage

// File: rtl/vid_sync_fifo.sv
// rtl/vid_sync_fifo.sv - first-word-fall-through FIFO with occupancy count
module vid_sync_fifo #(
  parameter int WIDTH = 26,
  parameter int DEPTH = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wr_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rd_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_level;
  logic             w_pop;
  logic             w_push;

  assign o_full  = (r_level == (AW+1)'(DEPTH));
  assign o_empty = (r_level == '0);
  assign o_level = r_level;

  // A push into a full FIFO is still taken when the same cycle frees a slot
  assign w_pop  = i_pop & ~o_empty;
  assign w_push = i_push & (~o_full | w_pop);

  assign o_rd_data = o_empty ? '0 : r_mem[r_rd_ptr];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      r_level <= r_level + (AW+1)'(w_push) - (AW+1)'(w_pop);
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wr_data;
  end

endmodule

// File: rtl/vid_raster_to_stream.sv
// rtl/vid_raster_to_stream.sv - raster video to tagged pixel stream via FIFO
// Optional line-length checker enabled by VID_LINE_CHECK_EN.
module vid_raster_to_stream
  import vid_pkg::*;
#(
  parameter int PW         = 8,
`ifdef VID_LINE_CHECK_EN
  parameter int H_BITS     = 12,
`endif
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_hs,
  input  logic                          i_vs,
  input  logic                          i_vld,
  input  logic [3*PW-1:0]               i_rgb,
  output logic [3*PW-1:0]               o_m_data,
  output logic                          o_m_sof,
  output logic                          o_m_eol,
  output logic                          o_m_valid,
  input  logic                          i_m_ready,
  output logic [$clog2(FIFO_DEPTH):0]   o_level,
  output logic                          o_ovf,
  input  logic                          i_ovf_clr,
  output logic                          o_hs_d
`ifdef VID_LINE_CHECK_EN
  ,
  input  logic [H_BITS-1:0]             i_exp_width,
  output logic                          o_line_err
`endif
);

  localparam int WW = word_width(PW);

  state_t             r_state;
  state_t             w_state_next;
  logic               r_vs_d;
  logic               r_hs_d;
  logic               r_hold_vld;
  logic               r_hold_sof;
  logic [3*PW-1:0]    r_hold_rgb;
  logic               r_ovf;
  logic               w_vs_rise;
  logic               w_accept;
  logic               w_push;
  logic               w_eol;
  logic               w_pop;
  logic               w_full;
  logic               w_empty;
  logic [WW-1:0]      w_wr_data;
  logic [WW-1:0]      w_rd_data;

  assign w_vs_rise = i_vs & ~r_vs_d;
  assign w_accept  = i_vld & (r_state != S_SYNC);
  assign w_push    = r_hold_vld;
  // Line end is only known one cycle later, when the next input is not a pixel
  assign w_eol     = ~i_vld | w_vs_rise;
  assign w_wr_data = {r_hold_sof, w_eol, r_hold_rgb};
  assign w_pop     = o_m_valid & i_m_ready;

  assign o_m_valid = ~w_empty;
  assign o_m_data  = w_rd_data[3*PW-1:0];
  assign o_m_sof   = w_rd_data[3*PW+SOF_BIT];
  assign o_m_eol   = w_rd_data[3*PW+EOL_BIT];
  assign o_ovf     = r_ovf;
  assign o_hs_d    = r_hs_d;

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_SYNC:   if (w_vs_rise) w_state_next = S_ARMED;
      S_ARMED:  if (i_vld)     w_state_next = S_ACTIVE;
      S_ACTIVE: if (w_vs_rise) w_state_next = S_ARMED;
      default:                 w_state_next = S_SYNC;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= S_SYNC;
      r_vs_d     <= 1'b0;
      r_hs_d     <= 1'b0;
      r_hold_vld <= 1'b0;
      r_hold_sof <= 1'b0;
      r_hold_rgb <= '0;
      r_ovf      <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_vs_d     <= i_vs;
      r_hs_d     <= i_hs;
      r_hold_vld <= w_accept;
      if (w_accept) begin
        r_hold_rgb <= i_rgb;
        r_hold_sof <= (r_state == S_ARMED);
      end
      if (w_push & w_full & ~w_pop) r_ovf <= 1'b1;
      else if (i_ovf_clr)           r_ovf <= 1'b0;
    end
  end

  vid_sync_fifo #(
    .WIDTH (WW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_push    (w_push),
    .i_wr_data (w_wr_data),
    .i_pop     (w_pop),
    .o_rd_data (w_rd_data),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_level   (o_level)
  );

`ifdef VID_LINE_CHECK_EN
  logic [H_BITS-1:0] r_pix_cnt;
  logic              r_line_err;

  assign o_line_err = r_line_err;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_pix_cnt  <= '0;
      r_line_err <= 1'b0;
    end else if (w_push) begin
      if (w_eol) begin
        r_pix_cnt <= '0;
        if (({1'b0, r_pix_cnt} + 1'b1) != {1'b0, i_exp_width}) r_line_err <= 1'b1;
      end else if (r_pix_cnt != '1) begin
        r_pix_cnt <= r_pix_cnt + 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_vid_raster_to_stream.sv
// tb/tb_vid_raster_to_stream.sv - directed self-checking bench for vid_raster_to_stream
module tb_vid_raster_to_stream;

  logic        clk = 1'b0;
  logic        rst;
  logic        hs, vs, vld, m_ready, ovf_clr;
  logic [23:0] rgb;
  logic [23:0] m_data;
  logic        m_sof, m_eol, m_valid, ovf, hs_d;
  logic [4:0]  level;
`ifdef VID_LINE_CHECK_EN
  logic [11:0] exp_width;
  logic        line_err;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vid_raster_to_stream dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_hs        (hs),
    .i_vs        (vs),
    .i_vld       (vld),
    .i_rgb       (rgb),
    .o_m_data    (m_data),
    .o_m_sof     (m_sof),
    .o_m_eol     (m_eol),
    .o_m_valid   (m_valid),
    .i_m_ready   (m_ready),
    .o_level     (level),
    .o_ovf       (ovf),
    .i_ovf_clr   (ovf_clr),
    .o_hs_d      (hs_d)
`ifdef VID_LINE_CHECK_EN
    ,
    .i_exp_width (exp_width),
    .o_line_err  (line_err)
`endif
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1; hs = 1'b0; vs = 1'b0; vld = 1'b0; rgb = '0;
    m_ready = 1'b0; ovf_clr = 1'b0;
    tick; tick;
    rst = 1'b0;
  endtask

  task automatic vs_pulse;
    vs = 1'b1;
    tick;
    vs = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; hs = 1'b0; vs = 1'b0; vld = 1'b0; rgb = '0;
    m_ready = 1'b0; ovf_clr = 1'b0;
`ifdef VID_LINE_CHECK_EN
    exp_width = 12'd4;
`endif
    tick; tick;
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", m_valid); end
    checks++; if (m_sof !== 1'b0) begin errors++; $display("FAIL reset_sof: got %b expected 0", m_sof); end
    checks++; if (m_eol !== 1'b0) begin errors++; $display("FAIL reset_eol: got %b expected 0", m_eol); end
    checks++; if (m_data !== 24'h0) begin errors++; $display("FAIL reset_data: got %h expected 0", m_data); end
    checks++; if (level !== 5'd0) begin errors++; $display("FAIL reset_level: got %0d expected 0", level); end
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
`ifdef VID_LINE_CHECK_EN
    checks++; if (line_err !== 1'b0) begin errors++; $display("FAIL reset_line_err: got %b expected 0", line_err); end
`endif
    rst = 1'b0;
  endtask

  task automatic test_no_sync;
    do_reset;
    hs = 1'b1;
    for (int i = 0; i < 10; i++) begin
      vld = 1'b1; rgb = 24'(i + 1);
      tick;
      checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL nosync_valid[%0d]: got %b expected 0", i, m_valid); end
    end
    vld = 1'b0; hs = 1'b0;
    tick; tick;
    checks++; if (level !== 5'd0) begin errors++; $display("FAIL nosync_level: got %0d expected 0", level); end
    checks++; if (hs_d !== 1'b0) begin errors++; $display("FAIL hs_reg: got %b expected 0", hs_d); end
  endtask

  task automatic test_single_line;
    logic [23:0] q_data[$];
    logic        q_sof[$];
    logic        q_eol[$];
    int          first_idx;
    first_idx = -1;
    do_reset;
    vs_pulse;
    m_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      vld = (c < 4);
      rgb = (c < 4) ? 24'(c + 1) : 24'h0;
      tick;
      if (m_valid === 1'b1) begin
        if (first_idx < 0) first_idx = c;
        q_data.push_back(m_data);
        q_sof.push_back(m_sof);
        q_eol.push_back(m_eol);
      end
    end
    checks++; if (first_idx !== 1) begin errors++; $display("FAIL line_latency: got first valid at %0d expected 1", first_idx); end
    checks++; if (q_data.size() !== 4) begin errors++; $display("FAIL line_count: got %0d expected 4", q_data.size()); end
    for (int i = 0; i < q_data.size() && i < 4; i++) begin
      checks++; if (q_data[i] !== 24'(i + 1)) begin errors++; $display("FAIL line_data[%0d]: got %h expected %h", i, q_data[i], 24'(i + 1)); end
      checks++; if (q_sof[i] !== (i == 0)) begin errors++; $display("FAIL line_sof[%0d]: got %b expected %b", i, q_sof[i], (i == 0)); end
      checks++; if (q_eol[i] !== (i == 3)) begin errors++; $display("FAIL line_eol[%0d]: got %b expected %b", i, q_eol[i], (i == 3)); end
    end
  endtask

  task automatic test_overflow;
    int n;
    do_reset;
    vs_pulse;
    m_ready = 1'b0;
    for (int i = 0; i < 20; i++) begin
      vld = 1'b1; rgb = 24'(i + 1);
      tick;
    end
    vld = 1'b0;
    tick; tick; tick;
    checks++; if (level !== 5'd16) begin errors++; $display("FAIL ovf_level: got %0d expected 16", level); end
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b expected 1", ovf); end
    m_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 40 && n < 16; c++) begin
      if (m_valid === 1'b1) begin
        checks++; if (m_data !== 24'(n + 1)) begin errors++; $display("FAIL ovf_order[%0d]: got %h expected %h", n, m_data, 24'(n + 1)); end
        n++;
      end
      tick;
    end
    checks++; if (n !== 16) begin errors++; $display("FAIL ovf_drain_count: got %0d expected 16", n); end
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL ovf_empty_after: got %b expected 0", m_valid); end
    checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b expected 1", ovf); end
    ovf_clr = 1'b1;
    tick;
    ovf_clr = 1'b0;
    checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b expected 0", ovf); end
  endtask

  task automatic test_back_to_back;
    int exp_v;
    exp_v = 1;
    do_reset;
    vs_pulse;
    m_ready = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      vld = 1'b1; rgb = 24'(k);
      if (m_ready) begin
        checks++; if (m_data !== 24'(exp_v)) begin errors++; $display("FAIL b2b_data: got %h expected %h", m_data, 24'(exp_v)); end
        exp_v++;
      end
      tick;
      if (k >= 17) begin
        checks++; if (level !== 5'd16) begin errors++; $display("FAIL b2b_level[%0d]: got %0d expected 16", k, level); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL b2b_ovf[%0d]: got %b expected 0", k, ovf); end
      end
      if (k == 17) m_ready = 1'b1;
    end
    vld = 1'b0;
    checks++; if (exp_v !== 14) begin errors++; $display("FAIL b2b_pops: got %0d expected 14", exp_v); end
  endtask

  task automatic test_reset_mid_line;
    logic found;
    found = 1'b0;
    do_reset;
    vs_pulse;
    m_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      vld = 1'b1; rgb = 24'hA1 + 24'(i);
      tick;
    end
    vld = 1'b0;
    tick; tick;
    checks++; if (level !== 5'd3) begin errors++; $display("FAIL mid_level_before: got %0d expected 3", level); end
    rst = 1'b1;
    tick;
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL mid_valid_after_rst: got %b expected 0", m_valid); end
    checks++; if (level !== 5'd0) begin errors++; $display("FAIL mid_level_after_rst: got %0d expected 0", level); end
    rst = 1'b0;
    m_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      vld = 1'b1; rgb = 24'hB0;
      tick;
    end
    vld = 1'b0;
    tick;
    checks++; if (m_valid !== 1'b0) begin errors++; $display("FAIL mid_drop_before_vs: got %b expected 0", m_valid); end
    vs_pulse;
    for (int c = 0; c < 8 && !found; c++) begin
      vld = (c < 2); rgb = 24'h10 + 24'(c);
      tick;
      if (m_valid === 1'b1) begin
        found = 1'b1;
        checks++; if (m_data !== 24'h10) begin errors++; $display("FAIL mid_first_data: got %h expected 10", m_data); end
        checks++; if (m_sof !== 1'b1) begin errors++; $display("FAIL mid_first_sof: got %b expected 1", m_sof); end
      end
    end
    vld = 1'b0;
    checks++; if (found !== 1'b1) begin errors++; $display("FAIL mid_timeout: got no output expected sof pixel"); end
  endtask

`ifdef VID_LINE_CHECK_EN
  task automatic test_line_check;
    do_reset;
    exp_width = 12'd4;
    m_ready = 1'b1;
    vs_pulse;
    for (int i = 0; i < 4; i++) begin
      vld = 1'b1; rgb = 24'(i);
      tick;
    end
    vld = 1'b0;
    tick; tick; tick;
    checks++; if (line_err !== 1'b0) begin errors++; $display("FAIL line_err_ok: got %b expected 0", line_err); end
    for (int i = 0; i < 5; i++) begin
      vld = 1'b1; rgb = 24'(i);
      tick;
    end
    vld = 1'b0;
    tick; tick; tick;
    checks++; if (line_err !== 1'b1) begin errors++; $display("FAIL line_err_bad: got %b expected 1", line_err); end
  endtask
`endif

  initial begin
    test_reset;
    test_no_sync;
    test_single_line;
    test_overflow;
    test_back_to_back;
    test_reset_mid_line;
`ifdef VID_LINE_CHECK_EN
    test_line_check;
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
